// File: rtl/frequency_meter.sv
// Gated rising-edge counter: reports how many edges of a slow asynchronous input fall in each GATE_CYCLES window.
// Optional peak-hold output (pico / borrar_pico) is compiled in when FREQ_PEAK_HOLD_EN is defined.
module frequency_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16,
  parameter int GATE_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   entrada,
`ifdef FREQ_PEAK_HOLD_EN
  input  logic                   borrar_pico,
  output logic [COUNT_WIDTH-1:0] pico,
`endif
  output logic [COUNT_WIDTH-1:0] medida,
  output logic                   valida,
  output logic                   desborde,
  output logic                   midiendo
);

  // valida is a one-cycle strobe with no back-pressure; medida and desborde take
  // the new result on the clock edge that ends the strobe and hold until the next one.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [GATE_WIDTH-1:0]  GATE_LOAD = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t                   state;
  state_t                   state_next;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     prev;
  logic                     detect;
  logic [COUNT_WIDTH-1:0]   edge_cnt;
  logic                     sticky;
  logic [GATE_WIDTH-1:0]    gate_cnt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    midiendo   = 1'b0;
    valida     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = GATE;
      end
      GATE: begin
        midiendo = 1'b1;
        if (gate_cnt == '0) state_next = LATCH;
      end
      LATCH: begin
        valida     = 1'b1;
        state_next = enable ? GATE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchroniser and edge detector run in every state so a rise landing in LATCH is still seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync   <= '0;
      prev   <= 1'b0;
      detect <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], entrada};
      prev   <= sync[SYNC_STAGES-1];
      detect <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      edge_cnt <= '0;
      sticky   <= 1'b0;
      gate_cnt <= '0;
      medida   <= '0;
      desborde <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            gate_cnt <= GATE_LOAD;
            edge_cnt <= '0;
            sticky   <= 1'b0;
          end
        end
        GATE: begin
          if (gate_cnt != '0) gate_cnt <= gate_cnt - GATE_WIDTH'(1);
          if (detect) begin
            if (edge_cnt == CNT_MAX) sticky <= 1'b1;
            else                     edge_cnt <= edge_cnt + COUNT_WIDTH'(1);
          end
        end
        LATCH: begin
          medida   <= edge_cnt;
          desborde <= sticky;
          edge_cnt <= COUNT_WIDTH'(detect);
          sticky   <= 1'b0;
          if (enable) gate_cnt <= GATE_LOAD;
        end
        default: ;
      endcase
    end
  end

`ifdef FREQ_PEAK_HOLD_EN
  // A clear that coincides with a new result restarts the peak from that result.
  always_ff @(posedge clock) begin
    if (reset)                                pico <= '0;
    else if (valida && borrar_pico)           pico <= edge_cnt;
    else if (borrar_pico)                     pico <= '0;
    else if (valida && (edge_cnt > pico))     pico <= edge_cnt;
  end
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: a 16-bit and a 3-bit (saturation) instance, both with a 100-cycle gate.
// Peak-hold scenario is exercised when FREQ_PEAK_HOLD_EN is defined.
module tb_frequency_meter;

  logic        clock;
  logic        reset;
  logic        enable_a;
  logic        enable_b;
  logic        entrada;
  logic [15:0] medida_a;
  logic        valida_a;
  logic        desborde_a;
  logic        midiendo_a;
  logic [2:0]  medida_b;
  logic        valida_b;
  logic        desborde_b;
  logic        midiendo_b;
`ifdef FREQ_PEAK_HOLD_EN
  logic        borrar_a;
  logic        borrar_b;
  logic [15:0] pico_a;
  logic [2:0]  pico_b;
`endif

  int checks = 0;
  int errors = 0;

  frequency_meter #(
    .GATE_CYCLES(100),
    .COUNT_WIDTH(16),
    .GATE_WIDTH(32),
    .SYNC_STAGES(2)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .enable(enable_a),
    .entrada(entrada),
`ifdef FREQ_PEAK_HOLD_EN
    .borrar_pico(borrar_a),
    .pico(pico_a),
`endif
    .medida(medida_a),
    .valida(valida_a),
    .desborde(desborde_a),
    .midiendo(midiendo_a)
  );

  frequency_meter #(
    .GATE_CYCLES(100),
    .COUNT_WIDTH(3),
    .GATE_WIDTH(32),
    .SYNC_STAGES(2)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .enable(enable_b),
    .entrada(entrada),
`ifdef FREQ_PEAK_HOLD_EN
    .borrar_pico(borrar_b),
    .pico(pico_b),
`endif
    .medida(medida_b),
    .valida(valida_b),
    .desborde(desborde_b),
    .midiendo(midiendo_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    entrada  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  function automatic logic square(input int k, input int period);
    return ((k - 1) % period) < (period / 2);
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      entrada = i[0];
      tick();
      if (medida_a !== 16'd0) begin errors++; $display("FAIL reset_medida cyc=%0d got %0d exp 0", i, medida_a); end
      checks++;
      if (valida_a !== 1'b0) begin errors++; $display("FAIL reset_valida cyc=%0d got %b exp 0", i, valida_a); end
      checks++;
      if (desborde_a !== 1'b0) begin errors++; $display("FAIL reset_desborde cyc=%0d got %b exp 0", i, desborde_a); end
      checks++;
      if (midiendo_a !== 1'b0) begin errors++; $display("FAIL reset_midiendo cyc=%0d got %b exp 0", i, midiendo_a); end
      checks++;
      if (medida_b !== 3'd0) begin errors++; $display("FAIL reset_medida_b cyc=%0d got %0d exp 0", i, medida_b); end
      checks++;
    end
    reset   = 1'b0;
    entrada = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (midiendo_a !== 1'b0 || valida_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got midiendo=%b valida=%b exp 0 0", i, midiendo_a, valida_a);
      end
      checks++;
    end
  endtask

  task automatic test_steady();
    logic exp_v;
    do_reset();
    for (int k = 1; k <= 304; k++) begin
      enable_a = 1'b1;
      entrada  = square(k, 10);
      tick();
      exp_v = (k == 101) || (k == 202) || (k == 303);
      if (valida_a !== exp_v) begin errors++; $display("FAIL steady_valida k=%0d got %b exp %b", k, valida_a, exp_v); end
      checks++;
      if (midiendo_a !== !exp_v) begin errors++; $display("FAIL steady_midiendo k=%0d got %b exp %b", k, midiendo_a, !exp_v); end
      checks++;
      if (k == 102 || k == 203 || k == 304) begin
        if (medida_a !== 16'd10) begin errors++; $display("FAIL steady_medida k=%0d got %0d exp 10", k, medida_a); end
        checks++;
        if (desborde_a !== 1'b0) begin errors++; $display("FAIL steady_desborde k=%0d got %b exp 0", k, desborde_a); end
        checks++;
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int k = 1; k <= 203; k++) begin
      enable_a = 1'b1;
      entrada  = (k >= 20 && k <= 22) || (k >= 50 && k <= 52) ||
                 (k >= 99 && k <= 101) || (k >= 150 && k <= 152);
      tick();
      if (k == 101 && valida_a !== 1'b1) begin errors++; $display("FAIL boundary_latch k=%0d got %b exp 1", k, valida_a); end
      if (k == 101) checks++;
      if (k == 102) begin
        if (medida_a !== 16'd2) begin errors++; $display("FAIL boundary_win1 k=%0d got %0d exp 2", k, medida_a); end
        checks++;
      end
      if (k == 203) begin
        if (medida_a !== 16'd2) begin errors++; $display("FAIL boundary_win2 k=%0d got %0d exp 2", k, medida_a); end
        checks++;
      end
    end
  endtask

  task automatic test_saturation();
    logic exp_v;
    do_reset();
    for (int k = 1; k <= 203; k++) begin
      enable_b = 1'b1;
      entrada  = (k <= 101) ? square(k, 6) : (((k - 102) % 40) < 20);
      tick();
      exp_v = (k == 101) || (k == 202);
      if (valida_b !== exp_v) begin errors++; $display("FAIL sat_valida k=%0d got %b exp %b", k, valida_b, exp_v); end
      checks++;
      if (k == 102) begin
        if (medida_b !== 3'd7) begin errors++; $display("FAIL sat_medida k=%0d got %0d exp 7", k, medida_b); end
        checks++;
        if (desborde_b !== 1'b1) begin errors++; $display("FAIL sat_desborde k=%0d got %b exp 1", k, desborde_b); end
        checks++;
      end
      if (k == 203) begin
        if (medida_b !== 3'd3) begin errors++; $display("FAIL sat_recover_medida k=%0d got %0d exp 3", k, medida_b); end
        checks++;
        if (desborde_b !== 1'b0) begin errors++; $display("FAIL sat_recover_desborde k=%0d got %b exp 0", k, desborde_b); end
        checks++;
      end
    end
    enable_b = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    for (int k = 1; k <= 250; k++) begin
      enable_a = (k < 50);
      entrada  = (k <= 100) ? square(k, 10) : 1'b0;
      tick();
      if (valida_a !== (k == 101)) begin errors++; $display("FAIL drop_valida k=%0d got %b exp %b", k, valida_a, (k == 101)); end
      checks++;
      if (midiendo_a !== (k <= 100)) begin errors++; $display("FAIL drop_midiendo k=%0d got %b exp %b", k, midiendo_a, (k <= 100)); end
      checks++;
      if (k == 102 || k == 250) begin
        if (medida_a !== 16'd10) begin errors++; $display("FAIL drop_medida k=%0d got %0d exp 10", k, medida_a); end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid_window();
    // medida still holds 10 from the previous scenario
    for (int k = 1; k <= 200; k++) begin
      reset    = (k == 50);
      enable_a = (k < 50);
      entrada  = (k <= 100) ? square(k, 10) : 1'b0;
      tick();
      if (valida_a !== 1'b0) begin errors++; $display("FAIL rst_mid_valida k=%0d got %b exp 0", k, valida_a); end
      checks++;
      if (k == 49) begin
        if (midiendo_a !== 1'b1) begin errors++; $display("FAIL rst_mid_open k=%0d got %b exp 1", k, midiendo_a); end
        checks++;
      end
      if (k == 50 || k == 200) begin
        if (medida_a !== 16'd0) begin errors++; $display("FAIL rst_mid_medida k=%0d got %0d exp 0", k, medida_a); end
        checks++;
        if (midiendo_a !== 1'b0) begin errors++; $display("FAIL rst_mid_midiendo k=%0d got %b exp 0", k, midiendo_a); end
        checks++;
      end
    end
    reset = 1'b0;
  endtask

`ifdef FREQ_PEAK_HOLD_EN
  function automatic logic burst(input int k, input int b, input int n);
    return (k >= b) && (k < b + 6 * n) && (((k - b) % 6) < 3);
  endfunction

  task automatic test_peak();
    do_reset();
    borrar_a = 1'b0;
    for (int k = 1; k <= 405; k++) begin
      enable_a = 1'b1;
      entrada  = burst(k, 10, 10) || burst(k, 111, 4) || burst(k, 212, 12) || burst(k, 313, 5);
      borrar_a = (k == 350) || (k == 405);
      tick();
      case (k)
        102: begin
          if (medida_a !== 16'd10) begin errors++; $display("FAIL peak_medida1 k=%0d got %0d exp 10", k, medida_a); end
          checks++;
          if (pico_a !== 16'd10) begin errors++; $display("FAIL peak_pico1 k=%0d got %0d exp 10", k, pico_a); end
          checks++;
        end
        203: begin
          if (medida_a !== 16'd4) begin errors++; $display("FAIL peak_medida2 k=%0d got %0d exp 4", k, medida_a); end
          checks++;
          if (pico_a !== 16'd10) begin errors++; $display("FAIL peak_pico2 k=%0d got %0d exp 10", k, pico_a); end
          checks++;
        end
        304: begin
          if (medida_a !== 16'd12) begin errors++; $display("FAIL peak_medida3 k=%0d got %0d exp 12", k, medida_a); end
          checks++;
          if (pico_a !== 16'd12) begin errors++; $display("FAIL peak_pico3 k=%0d got %0d exp 12", k, pico_a); end
          checks++;
        end
        350: begin
          if (pico_a !== 16'd0) begin errors++; $display("FAIL peak_clear k=%0d got %0d exp 0", k, pico_a); end
          checks++;
        end
        405: begin
          if (medida_a !== 16'd5) begin errors++; $display("FAIL peak_medida4 k=%0d got %0d exp 5", k, medida_a); end
          checks++;
          if (pico_a !== 16'd5) begin errors++; $display("FAIL peak_clear_valida k=%0d got %0d exp 5", k, pico_a); end
          checks++;
        end
        default: ;
      endcase
    end
    borrar_a = 1'b0;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    entrada  = 1'b0;
`ifdef FREQ_PEAK_HOLD_EN
    borrar_a = 1'b0;
    borrar_b = 1'b0;
`endif
    test_reset();
    test_steady();
    test_boundary();
    test_saturation();
    test_enable_drop();
    test_reset_mid_window();
`ifdef FREQ_PEAK_HOLD_EN
    test_peak();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
